// File: rtl/ss_dst_fifo_if.sv
// ---------------------------------------------------------------------------
// ss_dst_fifo_if
// Stream bundle between the copy engine (write side), the destination FIFO
// and the destination bus writer (read side).
//   m_dst_putn / m_dst / m_dst_last        : write strobe (active-low), data, end flag
//   m_dst_full / m_dst_almost_full         : back-pressure to the copy engine
//   wr_getn                                : read strobe (active-low) from bus writer
//   wr_dat / wr_last                       : first-word-fall-through head word
//   wr_empty / wr_almost_empty             : occupancy status for the bus writer
// Modports: slave = the FIFO itself, master = the surrounding engine/writer.
// ---------------------------------------------------------------------------
interface ss_dst_fifo_if;
  logic        m_dst_putn;
  logic [63:0] m_dst;
  logic        m_dst_last;
  logic        m_dst_full;
  logic        m_dst_almost_full;
  logic        wr_getn;
  logic [63:0] wr_dat;
  logic        wr_last;
  logic        wr_empty;
  logic        wr_almost_empty;

  modport slave (
    input  m_dst_putn, m_dst, m_dst_last, wr_getn,
    output m_dst_full, m_dst_almost_full, wr_dat, wr_last, wr_empty, wr_almost_empty
  );

  modport master (
    output m_dst_putn, m_dst, m_dst_last, wr_getn,
    input  m_dst_full, m_dst_almost_full, wr_dat, wr_last, wr_empty, wr_almost_empty
  );
endinterface

// File: rtl/ss_dst_fifo.sv
// ---------------------------------------------------------------------------
// ss_dst_fifo
// Destination data FIFO of the DMA datapath. Buffers 64-bit words plus an
// end-of-transfer flag from the copy engine and presents them to the bus
// writer on a first-word-fall-through port.
//
// Ports:
//   wb_clk_i  : system clock, rising edge
//   wb_rst_n  : asynchronous active-low reset
//   flush     : synchronous clear of pointers and count (storage untouched)
//   bus       : ss_dst_fifo_if.slave (write strobe/data, read strobe/head, flags)
//   level     : current occupancy, DEPTH_LOG2+1 bits
//   err_ovf   : sticky "put rejected" flag       (only with SS_DST_FIFO_CHK_EN)
//   err_udf   : sticky "get while empty" flag    (only with SS_DST_FIFO_CHK_EN)
//
// Build option: define SS_DST_FIFO_CHK_EN to add the sticky error checks.
// Acceptance rules are identical with and without it.
// ---------------------------------------------------------------------------
module ss_dst_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  flush,
  ss_dst_fifo_if.slave          bus,
  output logic [DEPTH_LOG2:0]   level
`ifdef SS_DST_FIFO_CHK_EN
  ,
  output logic                  err_ovf,
  output logic                  err_udf
`endif
);

  localparam int DATA_W = 64;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_TH   = CW'(AE_MARGIN);

  logic [DATA_W:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic [CW-1:0]           count;
  logic [DATA_W:0]         head;

  logic put_req;
  logic get_req;
  logic put_acc;
  logic get_acc;
  logic is_empty;

  assign put_req  = !bus.m_dst_putn;
  assign get_req  = !bus.wr_getn;
  assign is_empty = (count == '0);

  // A get needs a stored word (no bypass). A put into a full FIFO is still
  // accepted when a get frees a slot in the same cycle.
  assign get_acc = get_req && !is_empty;
  assign put_acc = put_req && ((count != DEPTH_C) || get_acc);

  // Control state: pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (put_acc) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (get_acc) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count + CW'(put_acc) - CW'(get_acc);
    end
  end

  // Storage: data only, never reset; flush leaves contents in place
  always_ff @(posedge wb_clk_i) begin
    if (put_acc && !flush) mem[wr_ptr] <= {bus.m_dst_last, bus.m_dst};
  end

  // Read port and flags decoded from count
  assign head                  = mem[rd_ptr];
  assign bus.wr_dat            = is_empty ? '0   : head[DATA_W-1:0];
  assign bus.wr_last           = is_empty ? 1'b0 : head[DATA_W];
  assign bus.wr_empty          = is_empty;
  assign bus.wr_almost_empty   = (count <= AE_TH);
  assign bus.m_dst_full        = (count == DEPTH_C);
  assign bus.m_dst_almost_full = (count >= AF_TH);
  assign level                 = count;

`ifdef SS_DST_FIFO_CHK_EN
  // Sticky protocol checks; only reset clears them, flush does not
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (put_req && !put_acc)  err_ovf <= 1'b1;
      if (get_req && is_empty)  err_udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ss_dst_fifo.sv
module tb_ss_dst_fifo;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_n;
  logic       flush;
  logic [4:0] level;
`ifdef SS_DST_FIFO_CHK_EN
  logic       err_ovf;
  logic       err_udf;
`endif

  ss_dst_fifo_if bus ();

  ss_dst_fifo #(
    .DEPTH_LOG2 (4),
    .AF_MARGIN  (2),
    .AE_MARGIN  (2)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_n (wb_rst_n),
    .flush    (flush),
    .bus      (bus),
    .level    (level)
`ifdef SS_DST_FIFO_CHK_EN
    ,
    .err_ovf  (err_ovf),
    .err_udf  (err_udf)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of {last, data} words plus sticky error bits
  logic [64:0] q[$];
  bit          m_ovf;
  bit          m_udf;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input bit putn, input bit getn, input logic [63:0] d,
                              input bit l, input bit fl);
    bit got;
    bit put_ok;
    got    = !getn && (q.size() > 0);
    put_ok = !putn && ((q.size() < 16) || got);
    if (!putn && !put_ok)        m_ovf = 1'b1;
    if (!getn && q.size() == 0)  m_udf = 1'b1;
    if (fl) begin
      q.delete();
    end else begin
      if (got)    void'(q.pop_front());
      if (put_ok) q.push_back({l, d});
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("level",      65'(level),                 65'(n));
    chk("empty",      65'(bus.wr_empty),          65'(n == 0));
    chk("aempty",     65'(bus.wr_almost_empty),   65'(n <= 2));
    chk("full",       65'(bus.m_dst_full),        65'(n == 16));
    chk("afull",      65'(bus.m_dst_almost_full), 65'(n >= 14));
    chk("head", {bus.wr_last, bus.wr_dat}, (n > 0) ? q[0] : 65'd0);
`ifdef SS_DST_FIFO_CHK_EN
    chk("err_ovf",    65'(err_ovf),               65'(m_ovf));
    chk("err_udf",    65'(err_udf),               65'(m_udf));
`endif
  endtask

  // Drive at the falling edge, let the rising edge act, check at the next falling edge
  task automatic step(input bit putn, input bit getn, input logic [63:0] d,
                      input bit l, input bit fl);
    bus.m_dst_putn = putn;
    bus.wr_getn    = getn;
    bus.m_dst      = d;
    bus.m_dst_last = l;
    flush          = fl;
    @(posedge wb_clk_i);
    model_update(putn, getn, d, l, fl);
    @(negedge wb_clk_i);
    check_all();
  endtask

  task automatic do_reset();
    bus.m_dst_putn = 1'b1;
    bus.wr_getn    = 1'b1;
    flush          = 1'b0;
    wb_rst_n       = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    check_all();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
  endtask

  initial begin
    bus.m_dst_putn = 1'b1;
    bus.wr_getn    = 1'b1;
    bus.m_dst      = '0;
    bus.m_dst_last = 1'b0;
    flush          = 1'b0;
    wb_rst_n       = 1'b0;
    m_ovf          = 1'b0;
    m_udf          = 1'b0;
    @(negedge wb_clk_i);
    do_reset();

    // Reset/idle with explicit values
    step(1, 1, '0, 0, 0);
    chk("rst_level",  65'(level), 65'd0);
    chk("rst_empty",  65'(bus.wr_empty), 65'd1);
    chk("rst_aempty", 65'(bus.wr_almost_empty), 65'd1);
    chk("rst_dat",    65'(bus.wr_dat), 65'd0);
    chk("rst_full",   65'(bus.m_dst_full), 65'd0);
    chk("rst_afull",  65'(bus.m_dst_almost_full), 65'd0);

    // Fill
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 64'h1000 + 64'(i), i == 15, 0);
      if (i == 12) chk("fill_af13", 65'(bus.m_dst_almost_full), 65'd0);
      if (i == 13) chk("fill_af14", 65'(bus.m_dst_almost_full), 65'd1);
      if (i == 14) chk("fill_full15", 65'(bus.m_dst_full), 65'd0);
    end
    chk("fill_full", 65'(bus.m_dst_full), 65'd1);
    chk("fill_level", 65'(level), 65'd16);

    // Drain
    for (int i = 0; i < 16; i++) begin
      chk("drain_dat",  65'(bus.wr_dat),  65'h1000 + 65'(i));
      chk("drain_last", 65'(bus.wr_last), 65'(i == 15));
      step(1, 0, '0, 0, 0);
    end
    chk("drain_empty", 65'(bus.wr_empty), 65'd1);

    // Refill, then put+get while full
    for (int i = 0; i < 16; i++) step(0, 1, 64'h2000 + 64'(i), 0, 0);
    step(0, 0, 64'hAAAA, 0, 0);
    chk("fullcc_level", 65'(level), 65'd16);
    for (int i = 0; i < 15; i++) step(1, 0, '0, 0, 0);
    chk("fullcc_dat", 65'(bus.wr_dat), 65'hAAAA);

    // Back to full, then a put with no get while full
    for (int i = 0; i < 15; i++) step(0, 1, 64'h3000 + 64'(i), 0, 0);
    step(0, 1, 64'hDEAD, 1, 0);
    chk("ovf_level", 65'(level), 65'd16);
`ifdef SS_DST_FIFO_CHK_EN
    chk("ovf_flag", 65'(err_ovf), 65'd1);
`endif
    // Flush wins over a simultaneous put
    step(0, 1, 64'hBEEF, 0, 1);
    chk("flush_level", 65'(level), 65'd0);
    chk("flush_empty", 65'(bus.wr_empty), 65'd1);
`ifdef SS_DST_FIFO_CHK_EN
    chk("flush_ovf", 65'(err_ovf), 65'd1);
`endif
    step(1, 0, '0, 0, 0);
`ifdef SS_DST_FIFO_CHK_EN
    chk("udf_flag", 65'(err_udf), 65'd1);
`endif

    // Put+get while empty: get is ignored
    step(0, 0, 64'h55, 0, 0);
    chk("emptycc_level", 65'(level), 65'd1);
    chk("emptycc_dat",   65'(bus.wr_dat), 65'h55);

    // Randomised traffic with phase-biased rates, occasional flush and one reset
    for (int i = 0; i < 3000; i++) begin
      int ph;
      int pp;
      int gp;
      bit putn;
      bit getn;
      bit fl;
      ph = (i / 200) % 3;
      pp = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
      gp = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
      putn = !($urandom_range(0, 99) < pp);
      getn = !($urandom_range(0, 99) < gp);
      fl   = ($urandom_range(0, 99) == 0);
      if (i == 1500) do_reset();
      step(putn, getn, {$urandom, $urandom}, 1'($urandom), fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
